// File: rtl/sdram_pkg.sv
// sdram_pkg: shared FSM encodings, port ids and default widths for the SDRAM user-port arbiter
package sdram_pkg;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACC, WAIT_WR, WAIT_RD} arb_state_e;
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;
    localparam int DEF_ADDR_W = 23;
    localparam int DEF_DATA_W = 32;
endpackage

// File: rtl/sdram_arb_pick.sv
// sdram_arb_pick: combinational two-port grant selection
// SDRAM_ARB_RR_EN selects round-robin on contention; otherwise port 0 has fixed priority
module sdram_arb_pick
    import sdram_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant,
    output logic       any_req
);
    assign any_req = |req;
`ifdef SDRAM_ARB_RR_EN
    assign grant = &req ? ~last : (req[1] ? PORT1 : PORT0);
`else
    logic unused_last;
    assign unused_last = last;
    assign grant = req[0] ? PORT0 : PORT1;
`endif
endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares the SDRAM controller user port between two requesters, one transaction in flight
// SDRAM_ARB_RR_EN enables round-robin arbitration (default: fixed priority to port 0)
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RD_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_rw,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_rw,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              sd_in_valid,
    output logic              sd_rw,
    output logic [ADDR_W-1:0] sd_user_addr,
    output logic [DATA_W-1:0] sd_data_in,
    input  logic              sd_busy,
    input  logic              sd_out_valid,
    input  logic [DATA_W-1:0] sd_data_out,
    output logic              err_timeout
);
    localparam int CNT_W = $clog2(RD_TIMEOUT + 1);
    arb_state_e state_q, state_d;
    logic grant_q, grant_d, last_q, pick, any_req, arb;
    logic rw_q, rw_d, in_valid_q, in_valid_d, err_q, err_d;
    logic rd_done, rd_timeout;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d, rd_val;
    logic [1:0] ack_q, ack_d, rvalid_q, rvalid_d;

    sdram_arb_pick u_pick (
        .req     ({p1_req, p0_req}),
        .last    (last_q),
        .grant   (pick),
        .any_req (any_req)
    );

`ifdef SDRAM_ARB_RR_EN
    logic last_d;
    assign last_d = arb ? pick : last_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_q <= PORT1;
        else last_q <= last_d;
    end
`else
    assign last_q = PORT1;
`endif

    assign arb        = state_q == IDLE && !sd_busy && any_req;
    assign rd_timeout = state_q == WAIT_RD && !sd_out_valid && cnt_q == CNT_W'(RD_TIMEOUT - 1);
    // the controller may answer a read before it ever shows busy, so WAIT_ACC also takes the response
    assign rd_done    = ((state_q == WAIT_RD || (state_q == WAIT_ACC && !rw_q)) && sd_out_valid) || rd_timeout;
    assign rd_val     = rd_timeout ? '0 : sd_data_out;

    always_comb begin
        case (state_q)
            IDLE:     state_d = arb ? ISSUE : IDLE;
            ISSUE:    state_d = WAIT_ACC;
            WAIT_ACC: state_d = rd_done ? IDLE : sd_busy ? (rw_q ? WAIT_WR : WAIT_RD) : WAIT_ACC;
            WAIT_WR:  state_d = sd_busy ? WAIT_WR : IDLE;
            WAIT_RD:  state_d = rd_done ? IDLE : WAIT_RD;
            default:  state_d = IDLE;
        endcase
        grant_d    = arb ? pick : grant_q;
        rw_d       = arb ? (pick ? p1_rw : p0_rw) : rw_q;
        addr_d     = arb ? (pick ? p1_addr : p0_addr) : addr_q;
        wdata_d    = arb ? (pick ? p1_wdata : p0_wdata) : wdata_q;
        in_valid_d = arb;
        ack_d      = arb ? (pick ? 2'b10 : 2'b01) : 2'b00;
        rvalid_d   = rd_done ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
        rdata0_d   = (rd_done && grant_q == PORT0) ? rd_val : rdata0_q;
        rdata1_d   = (rd_done && grant_q == PORT1) ? rd_val : rdata1_q;
        cnt_d      = (state_q == WAIT_RD && !rd_done) ? cnt_q + CNT_W'(1) : '0;
        err_d      = err_q | rd_timeout;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= PORT0;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            in_valid_q <= 1'b0;
            ack_q      <= '0;
            rvalid_q   <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            in_valid_q <= in_valid_d;
            ack_q      <= ack_d;
            rvalid_q   <= rvalid_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    assign sd_in_valid  = in_valid_q;
    assign sd_rw        = rw_q;
    assign sd_user_addr = addr_q;
    assign sd_data_in   = wdata_q;
    assign p0_ack       = ack_q[0];
    assign p1_ack       = ack_q[1];
    assign p0_rvalid    = rvalid_q[0];
    assign p1_rvalid    = rvalid_q[1];
    assign p0_rdata     = rdata0_q;
    assign p1_rdata     = rdata1_q;
    assign err_timeout  = err_q;
endmodule
